// File: rtl/register_renaming_unit_pkg.sv
// Types and 32-bit packet layouts shared by the renaming unit, its bus interface and the free list.
package register_renaming_unit_pkg;
    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_PHY_REGS  = 256;
    localparam int ARCH_REG_W    = 5;
    localparam int PHY_REG_W     = 8;
    localparam int ROB_INDEX_W   = 7;
    localparam int FREE_CNT_W    = PHY_REG_W + 1;
    localparam int RESET_FREE    = NUM_PHY_REGS - NUM_ARCH_REGS;

    typedef logic [ARCH_REG_W-1:0]  arch_register_id_t;
    typedef logic [PHY_REG_W-1:0]   phy_register_id_t;
    typedef logic [ROB_INDEX_W-1:0] rob_index_t;

    typedef struct packed {
        rob_index_t        rob_index;
        logic [9:0]        reserved;
        arch_register_id_t dest_arch_reg;
        arch_register_id_t src_arch_reg1;
        arch_register_id_t src_arch_reg2;
    } decoder_to_rru_t;

    typedef struct packed {
        rob_index_t       rob_index;
        logic             zero;
        phy_register_id_t dest_phy_reg;
        phy_register_id_t src_phy_reg1;
        phy_register_id_t src_phy_reg2;
    } rru_to_rob1_t;

    typedef struct packed {
        logic [23:0]      zero;
        phy_register_id_t prev_mapped_phy_reg;
    } rru_to_rob2_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND1,
        ST_SEND2
    } rru_state_t;
endpackage

// File: rtl/register_renaming_unit_if.sv
// Decoder input, ROB output and ROB commit/free-list status signals of the renaming unit.
interface register_renaming_unit_if;
    import register_renaming_unit_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    decoder_to_rru_t       in_packet;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_packet;
    logic                  out_last;
    logic                  free_valid;
    phy_register_id_t      free_phy_reg;
    logic [FREE_CNT_W-1:0] free_count;
    logic                  free_overflow;

    modport master (
        output in_valid, in_packet, out_ready, free_valid, free_phy_reg,
        input  in_ready, out_valid, out_packet, out_last, free_count, free_overflow
    );

    modport slave (
        input  in_valid, in_packet, out_ready, free_valid, free_phy_reg,
        output in_ready, out_valid, out_packet, out_last, free_count, free_overflow
    );
endinterface

// File: rtl/register_renaming_unit_free_list.sv
// Circular FIFO of free physical registers, reset to hold 32..255; pushes become poppable next cycle.
// Pushes of register 0 are ignored; pushes while full are dropped and raise a sticky overflow flag.
module rru_free_list
    import register_renaming_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  phy_register_id_t      push_reg,
    input  logic                  pop,
    output phy_register_id_t      head_reg,
    output logic [FREE_CNT_W-1:0] count,
    output logic                  overflow
);
    localparam logic [FREE_CNT_W-1:0] FULL_COUNT = FREE_CNT_W'(NUM_PHY_REGS);
    localparam logic [FREE_CNT_W-1:0] CNT_ONE    = FREE_CNT_W'(1);
    localparam phy_register_id_t      PTR_ONE    = PHY_REG_W'(1);

    phy_register_id_t mem [NUM_PHY_REGS];
    phy_register_id_t head;
    phy_register_id_t tail;
    logic             push_req;
    logic             do_push;
    logic             full;

    assign full     = (count == FULL_COUNT);
    assign push_req = push && (push_reg != '0);
    assign do_push  = push_req && !full;
    assign head_reg = mem[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHY_REGS; i++) begin
                mem[i] <= (i < RESET_FREE) ? PHY_REG_W'(i + NUM_ARCH_REGS) : '0;
            end
            head     <= '0;
            tail     <= PHY_REG_W'(RESET_FREE);
            count    <= FREE_CNT_W'(RESET_FREE);
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[tail] <= push_reg;
                tail      <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            if (push_req && full) begin
                overflow <= 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/register_renaming_unit.sv
// Renames one decoded instruction per accept and sends two beats to the ROB (ids, then previous mapping).
// At least 3 cycles per instruction; in_ready drops outside IDLE and when a real destination finds no free register.
module register_renaming_unit
    import register_renaming_unit_pkg::*;
(
    input logic                     clk,
    input logic                     rst,
    register_renaming_unit_if.slave bus
);
    rru_state_t            state;
    phy_register_id_t      rat [NUM_ARCH_REGS];
    rru_to_rob1_t          beat1;
    rru_to_rob2_t          beat2;
    rru_to_rob2_t          beat2_q;
    logic [31:0]           out_packet_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  dest_zero;
    logic                  in_ready;
    logic                  accept;
    phy_register_id_t      free_head;
    logic [FREE_CNT_W-1:0] free_count;
    logic                  free_overflow;

    assign dest_zero = (bus.in_packet.dest_arch_reg == '0);
    assign in_ready  = !rst && (state == ST_IDLE) && ((free_count != '0) || dest_zero);
    assign accept    = bus.in_valid && in_ready;

    rru_free_list u_free_list (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.free_valid),
        .push_reg (bus.free_phy_reg),
        .pop      (accept && !dest_zero),
        .head_reg (free_head),
        .count    (free_count),
        .overflow (free_overflow)
    );

    // Sources read the RAT as it stood before this instruction's own destination update.
    always_comb begin
        beat1 = '0;
        beat2 = '0;
        beat1.rob_index    = bus.in_packet.rob_index;
        beat1.src_phy_reg1 = rat[bus.in_packet.src_arch_reg1];
        beat1.src_phy_reg2 = rat[bus.in_packet.src_arch_reg2];
        if (!dest_zero) begin
            beat1.dest_phy_reg        = free_head;
            beat2.prev_mapped_phy_reg = rat[bus.in_packet.dest_arch_reg];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_packet_q <= '0;
            beat2_q      <= '0;
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                rat[i] <= PHY_REG_W'(i);
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!dest_zero) begin
                            rat[bus.in_packet.dest_arch_reg] <= free_head;
                        end
                        out_valid_q  <= 1'b1;
                        out_last_q   <= 1'b0;
                        out_packet_q <= beat1;
                        beat2_q      <= beat2;
                        state        <= ST_SEND1;
                    end
                end
                ST_SEND1: begin
                    if (bus.out_ready) begin
                        out_packet_q <= beat2_q;
                        out_last_q   <= 1'b1;
                        state        <= ST_SEND2;
                    end
                end
                ST_SEND2: begin
                    if (bus.out_ready) begin
                        out_valid_q  <= 1'b0;
                        out_last_q   <= 1'b0;
                        out_packet_q <= '0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_last      = out_last_q;
    assign bus.out_packet    = out_packet_q;
    assign bus.free_count    = free_count;
    assign bus.free_overflow = free_overflow;
endmodule
